// File: rtl/visual_mode_scheduler.sv
// Frame-synchronous source sequencer for the VGA visualizer mux: debounced switch,
// key and auto-demo requests, with a fade-out / switch / fade-in on vsync boundaries.
module visual_mode_scheduler #(
  parameter int NUM_MODES     = 9,
  parameter int FADE_STEP     = 32,
  parameter int DWELL_FRAMES  = 600,
  parameter int STABLE_FRAMES = 4
) (
  input  logic       iCLK_50,
  input  logic       iRST,
  input  logic       iVS,
  input  logic [3:0] iSW_MODE,
  input  logic       iKEY_NEXT_N,
  input  logic       iAUTO,
  output logic [3:0] oSEL,
  output logic [7:0] oGAIN,
  output logic       oLOCK,
  output logic       oBUSY
);

  typedef enum logic [1:0] {SHOW, FADE_OUT, SWITCH, FADE_IN} state_t;

  logic [1:0]  vs_sync, key_sync, auto_sync;
  logic [3:0]  sw_s0, sw_s1;
  logic        vs_d, vs_edge, key_d, key_evt;

  state_t      state, state_n;
  logic [3:0]  sel, sel_n, target, target_n, pend_mode, pend_mode_n;
  logic [7:0]  gain, gain_n;
  logic        pend_valid, pend_valid_n;
  logic [3:0]  sw_ref, sw_prev, stable_cnt;
  logic [15:0] dwell_cnt;

  logic        sw_fire, auto_fire, req_valid, eff_valid, start;
  logic [3:0]  base, inc_mode, req_mode, eff_mode;
  logic [8:0]  gain_dn, gain_up;

  // Synchronizers, vsync edge strobe and the sticky key event.
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      vs_sync   <= '0;
      key_sync  <= 2'b11;
      auto_sync <= '0;
      sw_s0     <= '0;
      sw_s1     <= '0;
      vs_d      <= 1'b0;
      vs_edge   <= 1'b0;
      key_d     <= 1'b1;
      key_evt   <= 1'b0;
    end else begin
      vs_sync   <= {vs_sync[0], iVS};
      key_sync  <= {key_sync[0], iKEY_NEXT_N};
      auto_sync <= {auto_sync[0], iAUTO};
      sw_s0     <= iSW_MODE;
      sw_s1     <= sw_s0;
      vs_d      <= vs_sync[1];
      vs_edge   <= vs_sync[1] & ~vs_d;
      key_d     <= key_sync[1];
      if (key_d & ~key_sync[1]) key_evt <= 1'b1;
      else if (vs_edge)         key_evt <= 1'b0;
    end
  end

  always_comb begin
    gain_dn   = ({1'b0, gain} > 9'(FADE_STEP)) ? {1'b0, gain} - 9'(FADE_STEP) : 9'd0;
    gain_up   = ({1'b0, gain} + 9'(FADE_STEP) > 9'd255) ? 9'd255 : {1'b0, gain} + 9'(FADE_STEP);
    sw_fire   = (stable_cnt == 4'(STABLE_FRAMES)) && (sw_s1 == sw_prev) &&
                (sw_s1 != sw_ref) && ({1'b0, sw_s1} < 5'(NUM_MODES));
    auto_fire = auto_sync[1] && (state == SHOW) && (dwell_cnt == 16'(DWELL_FRAMES - 1));
    base      = pend_valid ? pend_mode : ((state == FADE_OUT) ? target : sel);
    inc_mode  = ({1'b0, base} + 5'd1 >= 5'(NUM_MODES)) ? 4'd0 : base + 4'd1;
    req_valid = key_evt | sw_fire | auto_fire;
    req_mode  = key_evt ? inc_mode : (sw_fire ? sw_s1 : inc_mode);
    // A parked request beats anything new arriving on the first SHOW edge.
    eff_valid = pend_valid | req_valid;
    eff_mode  = pend_valid ? pend_mode : req_mode;
    start     = (state == SHOW) && eff_valid && (eff_mode != sel);
  end

  always_comb begin
    state_n      = state;
    sel_n        = sel;
    gain_n       = gain;
    target_n     = target;
    pend_valid_n = pend_valid;
    pend_mode_n  = pend_mode;
    if (vs_edge) begin
      case (state)
        SHOW: begin
          pend_valid_n = 1'b0;
          if (start) begin
            target_n = eff_mode;
            gain_n   = gain_dn[7:0];
            state_n  = (gain_dn == 9'd0) ? SWITCH : FADE_OUT;
          end
        end
        FADE_OUT: begin
          if (req_valid) target_n = req_mode;
          gain_n = gain_dn[7:0];
          if (gain_dn == 9'd0) state_n = SWITCH;
        end
        SWITCH: begin
          sel_n   = target;
          state_n = FADE_IN;
        end
        FADE_IN: begin
          gain_n = gain_up[7:0];
          if (gain_up == 9'd255) state_n = SHOW;
        end
        default: state_n = SHOW;
      endcase
      if ((state == SWITCH || state == FADE_IN) && req_valid) begin
        pend_valid_n = 1'b1;
        pend_mode_n  = req_mode;
      end
    end
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      state      <= SHOW;
      sel        <= '0;
      gain       <= 8'd255;
      target     <= '0;
      pend_valid <= 1'b0;
      pend_mode  <= '0;
      sw_ref     <= '0;
      sw_prev    <= '0;
      stable_cnt <= '0;
      dwell_cnt  <= '0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      gain       <= gain_n;
      target     <= target_n;
      pend_valid <= pend_valid_n;
      pend_mode  <= pend_mode_n;
      if (vs_edge) begin
        if (sw_s1 != sw_prev) begin
          sw_prev    <= sw_s1;
          stable_cnt <= '0;
        end else if (stable_cnt != 4'(STABLE_FRAMES)) begin
          stable_cnt <= stable_cnt + 4'd1;
        end
        if (sw_fire) sw_ref <= sw_s1;
        if (!auto_sync[1] || start) dwell_cnt <= '0;
        else if (state == SHOW)     dwell_cnt <= dwell_cnt + 16'd1;
      end
    end
  end

  assign oSEL  = sel;
  assign oGAIN = gain;
  assign oLOCK = (state == FADE_OUT) || (state == SWITCH);
  assign oBUSY = (state != SHOW);

endmodule
